pe_io_ctrl: RTL and testbench
=============================

PE_IO_CTRL -- requirements
Module: pe_io_ctrl

Interface
REQ-001 SHALL have parameter MESSAGE_WIDTH, default 5, LLR width.
REQ-002 SHALL have parameter DECISION_WIDTH, default 1, decision width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, PE memory address width.
REQ-004 SHALL have parameter FRAME_LEN, default 1<<ADDR_WIDTH, positions per frame, legal range 2..(1<<ADDR_WIDTH).
REQ-005 SHALL have ports:
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  enable  in  1  permits leaving IDLE.
  llr_valid  in  1  input LLR beat valid.
  llr_ready  out  1  input LLR beat accepted when high with llr_valid.
  llr_data  in  MESSAGE_WIDTH  channel LLR.
  out_valid  out  1  decision beat valid.
  out_ready  in  1  downstream accepts decision.
  out_data  out  DECISION_WIDTH  hard decision.
  out_last  out  1  marks position FRAME_LEN-1.
  run_start  out  1  one-cycle pulse to decoder core.
  run_done  in  1  one-cycle pulse from decoder core.
  mem_own  out  1  high while this block drives the PE memory address.
  mem_addr  out  ADDR_WIDTH  shared PE memory address.
  int_we, int_cs  out  2x1  intrinsic RAM write enable and chip select per bank [0:1].
  int_rs  out  1  intrinsic RAM select.
  int_wdata  out  2xMESSAGE_WIDTH  intrinsic write data, both banks [0:1].
  dec_cs  out  2x1  decision RAM chip select per bank [0:1].
  dec_rs  out  1  decision RAM select.
  dec_rdata  in  2xDECISION_WIDTH  decision RAM read data [0:1].
  busy  out  1  high in any state other than IDLE.

Function
REQ-006 SHALL implement FSM IDLE -> LOAD -> RUN -> UNLOAD -> IDLE; IDLE->LOAD when enable=1.
REQ-007 SHALL hold a bank register; int_rs and dec_rs SHALL both equal bank; bank SHALL toggle on the final UNLOAD handshake.
REQ-008 In LOAD: llr_ready=1, mem_own=1; each accepted beat SHALL assert int_we[bank] and int_cs[bank] in that same cycle, with mem_addr equal to the write count (0..FRAME_LEN-1) and int_wdata[0] and int_wdata[1] both equal to llr_data.
REQ-009 SHALL keep int_we and int_cs low for the non-selected bank, and outside LOAD handshakes.
REQ-010 The beat at count FRAME_LEN-1 SHALL move the FSM to RUN; run_start SHALL pulse for exactly one cycle in the first RUN cycle.
REQ-011 In RUN: mem_own=0, llr_ready=0, all chip selects 0; run_done SHALL move the FSM to UNLOAD; run_done in any other state SHALL be ignored.
REQ-012 In UNLOAD: mem_own=1; a read SHALL issue (dec_cs[bank]=1, mem_addr=read count) only when buffered + in-flight entries < 2; dec_rdata[bank] SHALL be captured one cycle after issue into a 2-entry output FIFO.
REQ-013 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head; out_last SHALL be 1 only for the entry read from address FRAME_LEN-1.
REQ-014 Decisions SHALL appear in address order with no loss or duplication under any out_ready pattern; with out_ready held at 1, throughput SHALL be one beat per cycle after a 2-cycle initial latency.
REQ-015 The handshake with out_last=1 SHALL return the FSM to IDLE, clear all counters, and toggle bank.
REQ-016 Counters SHALL be ADDR_WIDTH+1 bits wide and SHALL never wrap within a frame.

Reset
REQ-017 rst SHALL asynchronously force: state=IDLE, bank=0, all counters 0, FIFO empty, all outputs 0; rst asserted mid-frame SHALL abandon the frame without completing any further memory write.

Structure
REQ-018 State enum and the FIFO depth constant (2) SHALL reside in shared package pe_pkg.
REQ-019 The 2-entry output FIFO SHALL be sub-module pe_out_fifo; the FSM and counters SHALL remain in pe_io_ctrl.

Verification (FRAME_LEN=4, MESSAGE_WIDTH=5)
REQ-020 enable=1, LLRs 3,-2,7,-16 streamed back-to-back -> four writes to bank 0 at addresses 0..3 with int_we[1]=0 throughout, then a single run_start pulse.
REQ-021 run_done pulsed during LOAD -> ignored; pulsed in RUN -> UNLOAD begins the next cycle with dec_cs[0]=1 and mem_addr=0.
REQ-022 decisions 1,0,1,1 with out_ready=1 -> out_data 1,0,1,1 on consecutive cycles, out_last on the 4th beat, then IDLE with bank=1.
REQ-023 out_ready toggled 1,0,0,1,0,1... -> exact sequence 1,0,1,1, never more than 2 reads outstanding.
REQ-024 Second frame -> writes go to int_we[1] and int_rs=1.
REQ-025 rst asserted after 2 LLR beats -> immediate IDLE, bank=0, no further int_we.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the PE I/O controller: FSM states and output FIFO sizing.
package pe_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_UNLOAD} pe_state_e;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/pe_out_fifo.sv
// Two-entry decision FIFO carrying a last-position flag alongside each entry.
module pe_out_fifo
  import pe_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [W-1:0]          data_i,
  input  logic                  last_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [W-1:0]          data_o,
  output logic                  last_o,
  output logic [FIFO_CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][W-1:0] data_q;
  logic [FIFO_DEPTH-1:0]        last_q;
  logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
  logic [FIFO_CNT_W-1:0]        cnt_q;

  // The producer never pushes into a full FIFO; its issue rule counts in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      last_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= data_i;
        last_q[wr_ptr_q] <= last_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + FIFO_CNT_W'(push_i) - FIFO_CNT_W'(pop_i);
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = data_q[rd_ptr_q];
  assign last_o  = last_q[rd_ptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/pe_io_ctrl.sv
// PE I/O controller: streams a frame of LLRs into the intrinsic RAM bank, kicks the
// decoder core, then drains the decision RAM bank to a ready/valid output.
module pe_io_ctrl
  import pe_pkg::*;
#(
  parameter int MESSAGE_WIDTH  = 5,
  parameter int DECISION_WIDTH = 1,
  parameter int ADDR_WIDTH     = 8,
  parameter int FRAME_LEN      = 1 << ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                llr_valid,
  output logic                                llr_ready,
  input  logic [MESSAGE_WIDTH-1:0]            llr_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DECISION_WIDTH-1:0]           out_data,
  output logic                                out_last,
  output logic                                run_start,
  input  logic                                run_done,
  output logic                                mem_own,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [1:0]                          int_we,
  output logic [1:0]                          int_cs,
  output logic                                int_rs,
  output logic [1:0][MESSAGE_WIDTH-1:0]       int_wdata,
  output logic [1:0]                          dec_cs,
  output logic                                dec_rs,
  input  logic [1:0][DECISION_WIDTH-1:0]      dec_rdata,
  output logic                                busy
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  pe_state_e             state_q, state_d;
  logic                  bank_q, bank_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                  rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic                  run_start_q, run_start_d;
  logic [FIFO_CNT_W-1:0] fifo_cnt, occ;
  logic                  pop, issue;

  pe_out_fifo #(.W(DECISION_WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_vld_q),
    .data_i  (dec_rdata[bank_q]),
    .last_i  (rd_last_q),
    .pop_i   (pop),
    .valid_o (out_valid),
    .data_o  (out_data),
    .last_o  (out_last),
    .count_o (fifo_cnt)
  );

  // Occupancy after this cycle's pop, so a steady drain keeps one read issued per cycle.
  assign pop   = out_valid && out_ready;
  assign occ   = fifo_cnt + FIFO_CNT_W'(rd_vld_q) - FIFO_CNT_W'(pop);
  assign issue = (state_q == ST_UNLOAD) && (rd_cnt_q <= LAST_IDX)
                 && (occ < FIFO_CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_vld_d    = 1'b0;
    rd_last_d   = 1'b0;
    run_start_d = 1'b0;
    llr_ready   = 1'b0;
    mem_own     = 1'b0;
    mem_addr    = '0;
    int_we      = '0;
    int_cs      = '0;
    int_wdata   = '0;
    dec_cs      = '0;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_LOAD;
      ST_LOAD: begin
        llr_ready = 1'b1;
        mem_own   = 1'b1;
        mem_addr  = wr_cnt_q[ADDR_WIDTH-1:0];
        int_wdata = {llr_data, llr_data};
        if (llr_valid) begin
          int_we[bank_q] = 1'b1;
          int_cs[bank_q] = 1'b1;
          wr_cnt_d       = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            state_d     = ST_RUN;
            run_start_d = 1'b1;
          end
        end
      end
      ST_RUN: if (run_done) state_d = ST_UNLOAD;
      ST_UNLOAD: begin
        mem_own  = 1'b1;
        mem_addr = rd_cnt_q[ADDR_WIDTH-1:0];
        if (issue) begin
          dec_cs[bank_q] = 1'b1;
          rd_cnt_d       = rd_cnt_q + 1'b1;
          rd_vld_d       = 1'b1;
          rd_last_d      = (rd_cnt_q == LAST_IDX);
        end
        if (pop && out_last) begin
          state_d  = ST_IDLE;
          bank_d   = ~bank_q;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bank_q      <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      run_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      run_start_q <= run_start_d;
    end
  end

  assign run_start = run_start_q;
  assign int_rs    = bank_q;
  assign dec_rs    = bank_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pe_io_ctrl.sv
// Directed frame sequence for pe_io_ctrl with random LLRs, decisions and backpressure;
// expectations come from per-frame queues and a memory image kept by the bench.
module tb_pe_io_ctrl;
  localparam int MW = 5, DW = 1, AW = 2, FL = 4;

  logic clk = 1'b0;
  logic rst, enable, llr_valid, llr_ready, out_valid, out_ready, out_last;
  logic run_start, run_done, mem_own, int_rs, dec_rs, busy;
  logic [MW-1:0] llr_data;
  logic [DW-1:0] out_data;
  logic [AW-1:0] mem_addr;
  logic [1:0] int_we, int_cs, dec_cs;
  logic [1:0][MW-1:0] int_wdata;
  logic [1:0][DW-1:0] dec_rdata;

  logic [MW-1:0] int_ram [2][FL];
  logic [DW-1:0] dec_ram [2][FL];
  logic [MW-1:0] exp_int [2][FL];
  logic [MW-1:0] llr_v [FL];
  int errors = 0, checks = 0;

  pe_io_ctrl #(.MESSAGE_WIDTH(MW), .DECISION_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .llr_valid(llr_valid), .llr_ready(llr_ready),
    .llr_data(llr_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .run_start(run_start), .run_done(run_done), .mem_own(mem_own),
    .mem_addr(mem_addr), .int_we(int_we), .int_cs(int_cs), .int_rs(int_rs),
    .int_wdata(int_wdata), .dec_cs(dec_cs), .dec_rs(dec_rs), .dec_rdata(dec_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAMs: writes land on the edge, reads return one cycle after chip select.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (int_we[b] && int_cs[b]) int_ram[b][mem_addr] <= int_wdata[b];
      if (dec_cs[b]) dec_rdata[b] <= dec_ram[b][mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input bit gaps, input bit rd_in_load, input bit bk);
    int i = 0;
    int guard = 0;
    while (i < FL && guard < 100) begin
      tick();
      guard++;
      llr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      llr_data  = llr_valid ? llr_v[i] : MW'($urandom);
      run_done  = rd_in_load && (i == 1);
      #1;
      chk("load_ready", 32'(llr_ready), 1);
      chk("load_own", 32'(mem_own), 1);
      if (llr_valid) begin
        chk("load_we", 32'(int_we), 1 << bk);
        chk("load_cs", 32'(int_cs), 1 << bk);
        chk("load_addr", 32'(mem_addr), i);
        chk("load_wd0", 32'(int_wdata[0]), 32'(llr_v[i]));
        chk("load_wd1", 32'(int_wdata[1]), 32'(llr_v[i]));
        chk("load_rs", 32'(int_rs), 32'(bk));
        exp_int[bk][i] = llr_v[i];
        i++;
      end else begin
        chk("load_gap_we", 32'({int_we, int_cs}), 0);
      end
    end
    chk("load_bound", 32'(i), FL);
    tick();
    llr_valid = 1'b0;
    run_done  = 1'b0;
    #1;
    chk("run_start", 32'(run_start), 1);
    chk("run_own", 32'(mem_own), 0);
    chk("run_ready", 32'(llr_ready), 0);
    chk("run_cs", 32'({int_cs, dec_cs}), 0);
    for (int k = 0; k < FL; k++) begin
      chk("int_ram", 32'(int_ram[bk][k]), 32'(llr_v[k]));
      chk("int_ram_other", 32'(int_ram[!bk][k]), 32'(exp_int[!bk][k]));
    end
  endtask

  task automatic run_phase(input int wait_n);
    repeat (wait_n) begin
      tick();
      #1;
      chk("run_pulse_once", 32'(run_start), 0);
      chk("run_busy", 32'(busy), 1);
    end
    tick();
    run_done = 1'b1;
    #1;
    chk("run_hold_own", 32'(mem_own), 0);
    chk("run_hold_cs", 32'(dec_cs), 0);
    tick();
    run_done = 1'b0;
  endtask

  // mode 0: out_ready=1, mode 1: 1,0,0,1,0,1..., mode 2: random
  task automatic unload(input int mode, input bit bk);
    logic [DW-1:0] q[$];
    int c = 0, issued = 0, got = 0;
    bit done = 1'b0;
    for (int k = 0; k < FL; k++) q.push_back(dec_ram[bk][k]);
    while (!done && c < 200) begin
      if (c > 0) tick();
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c == 0) ? 1'b1 : (c < 3) ? 1'b0 : (c % 2 == 1);
        default: out_ready = $urandom_range(0, 1) != 0;
      endcase
      #1;
      if (c == 0) begin
        chk("ul_first_cs", 32'(dec_cs), 1 << bk);
        chk("ul_first_addr", 32'(mem_addr), 0);
      end
      chk("ul_own", 32'(mem_own), 1);
      chk("ul_no_write", 32'({int_we, int_cs}), 0);
      if (dec_cs != 2'b00) begin
        chk("ul_rd_cs", 32'(dec_cs), 1 << bk);
        chk("ul_rd_addr", 32'(mem_addr), issued);
        issued++;
      end
      if (out_valid && out_ready) begin
        if (q.size() > 0) chk("ul_data", 32'(out_data), 32'(q.pop_front()));
        else chk("ul_extra_beat", 32'(got), FL - 1);
        chk("ul_last", 32'(out_last), 32'(got == FL - 1));
        if (mode == 0) chk("ul_latency", c, 2 + got);
        got++;
        done = out_last;
      end
      chk("ul_outstanding", 32'((issued - got) <= 2), 1);
      c++;
    end
    chk("ul_beats", got, FL);
    chk("ul_reads", issued, FL);
    tick();
    out_ready = 1'b0;
    #1;
    chk("end_busy", 32'(busy), 0);
    chk("end_int_rs", 32'(int_rs), 32'(!bk));
    chk("end_dec_rs", 32'(dec_rs), 32'(!bk));
    chk("end_valid", 32'(out_valid), 0);
  endtask

  task automatic rand_frame(input bit bk);
    for (int k = 0; k < FL; k++) begin
      llr_v[k] = MW'($urandom);
      dec_ram[bk][k] = DW'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; llr_valid = 1'b0; llr_data = '0;
    run_done = 1'b0; out_ready = 1'b0;
    tick();
    #1;
    chk("rst_ctrl", 32'({busy, llr_ready, mem_own, run_start, out_valid, int_rs, dec_rs}), 0);
    chk("rst_mem", 32'({int_we, int_cs, dec_cs, mem_addr}), 0);
    tick();
    rst = 1'b0; llr_valid = 1'b1; run_done = 1'b1;
    #1;
    chk("idle_ready", 32'(llr_ready), 0);
    tick();
    run_done = 1'b0; llr_valid = 1'b0;
    #1;
    chk("idle_no_enable", 32'(busy), 0);
    enable = 1'b1;

    // Frame 1: fixed vectors into bank 0, run_done during LOAD must be ignored
    llr_v[0] = 5'd3; llr_v[1] = 5'b11110; llr_v[2] = 5'd7; llr_v[3] = 5'b10000;
    dec_ram[0][0] = 1'b1; dec_ram[0][1] = 1'b0; dec_ram[0][2] = 1'b1; dec_ram[0][3] = 1'b1;
    load_frame(1'b0, 1'b1, 1'b0);
    run_phase(2);
    unload(0, 1'b0);

    // Frame 2: bank 1 with input gaps and the toggling ready pattern
    rand_frame(1'b1);
    load_frame(1'b1, 1'b0, 1'b1);
    run_phase(0);
    unload(1, 1'b1);

    // Frame 3: bank 0 with random backpressure
    rand_frame(1'b0);
    load_frame(1'b1, 1'b0, 1'b0);
    run_phase(3);
    unload(2, 1'b0);

    // Frame 4: reset after two beats into bank 1
    for (int k = 0; k < 2; k++) begin
      tick();
      llr_valid = 1'b1;
      llr_data  = MW'($urandom);
      #1;
      chk("f4_we", 32'(int_we), 2);
      exp_int[1][k] = llr_data;
    end
    tick();
    llr_data = MW'($urandom);
    #1;
    rst = 1'b1;
    #1;
    chk("f4_rst_busy", 32'(busy), 0);
    chk("f4_rst_we", 32'({int_we, int_cs}), 0);
    chk("f4_rst_bank", 32'(int_rs), 0);
    chk("f4_rst_ready", 32'(llr_ready), 0);
    tick();
    tick();
    rst = 1'b0; llr_valid = 1'b0; enable = 1'b0;
    #1;
    for (int k = 0; k < FL; k++) chk("f4_ram_kept", 32'(int_ram[1][k]), 32'(exp_int[1][k]));
    chk("f4_idle", 32'(busy), 0);
    enable = 1'b1;
    tick();
    llr_valid = 1'b1;
    llr_data  = 5'd9;
    #1;
    chk("post_rst_we", 32'(int_we), 1);
    chk("post_rst_addr", 32'(mem_addr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
